// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single UART transmit line among NUM_REQ byte requesters. A
// round-robin arbiter picks one requester while the line is free, captures its
// byte, and a small frame sequencer then shifts out a start bit, the data bits
// LSB first, an optional parity bit, and a stop bit. Every line transition
// happens on a TX_tick strobe from an external baud generator.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   DATA_WIDTH  data bits per frame
//   GW          width of grant_id
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-low reset
//   TX_tick     one-clock bit-period strobe
//   req_valid   per-requester byte valid, held until accepted
//   req_data    requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   one-hot, single-cycle accept pulse
//   tx          serial line, idle high
//   busy        high from the cycle after accept until the frame ends
//   grant_id    index of the most recently granted requester
//   frame_done  single-cycle pulse on the tick that completes the stop bit
//
// Build option
//   UART_ARB_PARITY_EN  when defined, an even-parity bit (XOR of the data
//                       bits) is sent between the last data bit and the stop
//                       bit. When undefined the frame has no parity bit.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GW         = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          TX_tick,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [GW-1:0]                 grant_id,
  output logic                          frame_done
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ALIGN  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
`ifdef UART_ARB_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q,   cnt_d;
  logic                  tx_q,    tx_d;
  logic                  busy_q,  busy_d;
  logic [GW-1:0]         last_q,  last_d;
  logic [GW-1:0]         grant_q, grant_d;
`ifdef UART_ARB_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // Split the flat data bus into one word per requester.
  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign req_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: the first valid requester at or after last+1, wrapping.
  // The loop walks the rotation from the far end backwards so that the last
  // hit written is the closest one to last+1.
  // ---------------------------------------------------------------------------
  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic [GW-1:0] cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = GW'((int'(last_q) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Accept only from a free IDLE state; held off while reset is asserted so
  // req_ready reads 0 during reset.
  logic accept;
  assign accept = rst && (state_q == ST_IDLE) && !busy_q && pick_found;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = accept && (pick_idx == GW'(gi));
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Outside IDLE nothing moves except on TX_tick, so tx only
  // ever changes on a tick. The tick coincident with an accept is ignored
  // because IDLE does not look at it; ALIGN then waits for the next tick so
  // the start bit lasts one full bit period.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    last_d     = last_q;
    grant_d    = grant_q;
`ifdef UART_ARB_PARITY_EN
    parity_d   = parity_q;
`endif
    frame_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d  = req_word[pick_idx];
`ifdef UART_ARB_PARITY_EN
          parity_d = ^req_word[pick_idx];
`endif
          last_d   = pick_idx;
          grant_d  = pick_idx;
          busy_d   = 1'b1;
          state_d  = ST_ALIGN;
        end
      end

      ST_ALIGN: begin
        if (TX_tick) begin
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (TX_tick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (TX_tick) begin
          if (cnt_q < CW'(DATA_WIDTH - 1)) begin
            cnt_d   = cnt_q + CW'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end else begin
`ifdef UART_ARB_PARITY_EN
            tx_d    = parity_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end
        end
      end

`ifdef UART_ARB_PARITY_EN
      ST_PARITY: begin
        if (TX_tick) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        // frame_done is combinational so the following cycle, already back
        // in IDLE, is the earliest possible next accept.
        if (TX_tick) begin
          frame_done = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset leaves requester 0 first in line (last = NUM_REQ-1)
  // and drives the line high immediately, discarding any frame in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      last_q   <= GW'(NUM_REQ - 1);
      grant_q  <= '0;
`ifdef UART_ARB_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
`ifdef UART_ARB_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_WIDTH=8).
// A table of single-frame vectors, a few hand-written multi-cycle sequences
// (tick coincident with accept, withdrawn request, mid-frame reset), and a
// randomized run against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;
`ifdef UART_ARB_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Number of line bits driven by ticks: start, data, optional parity, stop.
  localparam int NB = W + 2 + PAR;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         TX_tick = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic         tx;
  logic         busy;
  logic [1:0]   grant_id;
  logic         frame_done;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .TX_tick   (TX_tick),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id),
    .frame_done(frame_done)
  );

  int total = 0;
  int bad   = 0;

  // Combinational outputs captured just before the active edge.
  logic [N-1:0] s_ready;
  logic         s_fd;

  typedef struct {
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    int             exp_g;
    logic [W-1:0]   exp_byte;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: inputs are already applied at posedge+1; combinational outputs
  // are sampled at posedge+3, registered outputs are readable at posedge+1.
  task automatic step(input logic tick);
    TX_tick = tick;
    #2;
    s_ready = req_ready;
    s_fd    = frame_done;
    @(posedge clk);
    #1;
    TX_tick = 1'b0;
  endtask

  // Accept one request and walk its frame tick by tick, with two idle clocks
  // between ticks so the line is seen to hold between strobes.
  task automatic run_frame(input logic [N-1:0] v, input logic [N*W-1:0] d,
                           input int exp_g, input logic [W-1:0] exp_byte,
                           input logic tick_on_accept);
    logic bits [$];
    logic cur;
    bits.delete();
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(exp_byte[i]);
    if (PAR != 0) bits.push_back(^exp_byte);
    bits.push_back(1'b1);

    req_valid = v;
    req_data  = d;
    step(tick_on_accept);
    chk("accept_ready", s_ready, 32'(1) << exp_g);
    chk("accept_busy", busy, 1);
    chk("accept_grant", grant_id, exp_g);
    chk("accept_tx_idle", tx, 1);
    // Request still held: must not be accepted again while busy.
    step(1'b0);
    chk("ready_one_cycle", s_ready, 0);
    req_valid = '0;

    cur = 1'b1;
    for (int k = 0; k <= NB; k++) begin
      step(1'b0);
      chk("tx_hold", tx, cur);
      step(1'b0);
      chk("tx_hold", tx, cur);
      chk("fd_between_ticks", s_fd, 0);
      step(1'b1);
      if (k < NB) begin
        chk("tx_bit", tx, bits[k]);
        chk("fd_early", s_fd, 0);
        cur = bits[k];
      end else begin
        chk("fd_end", s_fd, 1);
        chk("tx_after_stop", tx, 1);
      end
    end
    step(1'b0);
    chk("busy_cleared", busy, 0);
    $display("frame valid=%b grant=%0d byte=%h ticks=%0d", v, grant_id, exp_byte, NB + 1);
  endtask

  // Reference-model state for the randomized run.
  int         m_last;
  int         m_gid;
  logic       m_busy;
  logic       m_tx;
  logic       m_q [$];

  initial begin
    logic [N-1:0] v;
    logic [N*W-1:0] d;
    logic tick;
    logic [N-1:0] exp_ready;
    logic exp_fd;
    logic seen;
    logic [W-1:0] byte_v;
    int g;

    tbl[0]  = '{4'b0001, 32'h0000_00A5, 0, 8'hA5};
    tbl[1]  = '{4'b1111, 32'h4433_2211, 1, 8'h22};
    tbl[2]  = '{4'b1111, 32'h4433_2211, 2, 8'h33};
    tbl[3]  = '{4'b1111, 32'h4433_2211, 3, 8'h44};
    tbl[4]  = '{4'b1111, 32'h4433_2211, 0, 8'h11};
    tbl[5]  = '{4'b1010, 32'h4433_2211, 1, 8'h22};
    tbl[6]  = '{4'b1001, 32'h4433_2211, 3, 8'h44};
    tbl[7]  = '{4'b0100, 32'h4433_2211, 2, 8'h33};
    tbl[8]  = '{4'b0011, 32'h4433_2211, 0, 8'h11};
    tbl[9]  = '{4'b1000, 32'h4433_2211, 3, 8'h44};
    tbl[10] = '{4'b0001, 32'h0000_0007, 0, 8'h07};
    tbl[11] = '{4'b0001, 32'h0000_0003, 0, 8'h03};

    // ---- reset state (requests present but reset held) ----
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'hF;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_grant", grant_id, 0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b1;
    step(1'b0);
    chk("idle_ready", s_ready, 0);

    // ---- table-driven frames ----
    for (int i = 0; i < 12; i++) begin
      run_frame(tbl[i].valid, tbl[i].data, tbl[i].exp_g, tbl[i].exp_byte, 1'b0);
    end

    // ---- tick coincident with accept: start bit on the following tick ----
    run_frame(4'b0100, 32'h00FF_0000, 2, 8'hFF, 1'b1);

    // ---- withdrawn request while busy ----
    req_valid = 4'b0001;
    req_data  = 32'h0000_0055;
    step(1'b0);
    chk("wd_accept", s_ready, 4'b0001);
    req_valid = '0;
    step(1'b1);
    step(1'b1);
    req_valid = 4'b0100;
    step(1'b0);
    chk("wd_ready2", s_ready, 0);
    req_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1'b1);
      if (s_fd) seen = 1'b1;
    end
    chk("wd_frame_done", seen, 1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      chk("wd_no_grant", s_ready, 0);
    end
    chk("wd_grant_id", grant_id, 0);
    $display("withdrawn request 2 skipped, grant stays %0d", grant_id);

    // ---- asynchronous reset during data bit 3 ----
    req_valid = 4'b0010;
    req_data  = 32'h0000_0000;
    step(1'b0);
    chk("mr_accept", s_ready, 4'b0010);
    req_valid = '0;
    step(1'b1);                 // start bit
    step(1'b1);                 // bit 0
    step(1'b1);                 // bit 1
    step(1'b1);                 // bit 2
    step(1'b1);                 // bit 3
    chk("mr_busy_before", busy, 1);
    chk("mr_tx_low", tx, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_tx_async", tx, 1);
    chk("mr_busy_async", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("mr_grant_reset", grant_id, 0);
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step(1'b1);
      if (s_fd) seen = 1'b1;
    end
    chk("mr_no_frame_done", seen, 0);
    $display("mid-frame reset: line released, byte discarded");
    run_frame(4'b0011, 32'h0000_5A3C, 0, 8'h3C, 1'b0);

    // ---- randomized run against a frame-level model ----
    rst = 1'b0;
    step(1'b0);
    rst = 1'b1;
    step(1'b0);
    m_last = N - 1;
    m_gid  = 0;
    m_busy = 1'b0;
    m_tx   = 1'b1;
    m_q.delete();
    for (int c = 0; c < 3000; c++) begin
      v    = N'($urandom_range(0, 15));
      d    = $urandom;
      tick = ($urandom_range(0, 2) == 0);
      req_valid = v;
      req_data  = d;

      exp_ready = '0;
      exp_fd    = 1'b0;
      if (m_busy) begin
        if (tick) begin
          if (m_q.size() > 0) m_tx = m_q.pop_front();
          else begin
            exp_fd = 1'b1;
            m_busy = 1'b0;
          end
        end
      end else if (v != 0) begin
        g = -1;
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && v[(m_last + k) % N]) g = (m_last + k) % N;
        end
        exp_ready = N'(1) << g;
        m_last = g;
        m_gid  = g;
        m_busy = 1'b1;
        byte_v = d[g*W +: W];
        m_q.push_back(1'b0);
        for (int i = 0; i < W; i++) m_q.push_back(byte_v[i]);
        if (PAR != 0) m_q.push_back(^byte_v);
        m_q.push_back(1'b1);
        $display("rand cycle=%0d valid=%b grant=%0d byte=%h", c, v, g, byte_v);
      end

      step(tick);
      chk("rnd_ready", s_ready, exp_ready);
      chk("rnd_fd", s_fd, exp_fd);
      chk("rnd_tx", tx, m_tx);
      chk("rnd_busy", busy, m_busy);
      chk("rnd_grant", grant_id, m_gid);
    end
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and frame sequencer that shares one UART transmit line among `NUM_REQ` byte requesters. It sits downstream of the baud generator and consumes its single-cycle `TX_tick` pulse as the bit-period strobe. It grants one requester at a time, captures that requester's byte, and serializes it as a start bit, the data bits LSB first, an optional parity bit, and a stop bit.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `DATA_WIDTH`, default 8: bits per frame.
- `GW`, default `$clog2(NUM_REQ)`: width of `grant_id`.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `TX_tick`  in  1  bit-period strobe from the baud generator; high for one clock per bit period.
- `req_valid`  in  NUM_REQ  per-requester byte valid; held high until accepted.
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot, one-cycle accept pulse.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high from accept until frame end.
- `grant_id`  out  GW  index of the last granted requester.
- `frame_done`  out  1  one-cycle pulse when the stop bit completes.

## Operation
- **States:** IDLE, ALIGN, START, DATA, PARITY (only with macro), STOP.
- **IDLE:**
  - If any `req_valid` is high, pick the first requester at or after `(last+1) mod NUM_REQ`, scanning upward with wrap.
  - Assert `req_ready[g]` for that cycle, latch `req_data[g]` into the shift register, set `grant_id`/`last` to g, set `busy`, and go to ALIGN.
  - A `TX_tick` in the same cycle is ignored.
- **ALIGN:** on `TX_tick`, drive `tx`=0 and go to START. This aligns the start bit to a tick boundary.
- **START:** on `TX_tick`, drive `tx`=bit0, clear the bit counter, and go to DATA.
- **DATA:**
  - On `TX_tick` with counter < DATA_WIDTH-1: increment the counter and drive the next bit.
  - On `TX_tick` at the last bit: drive parity and go to PARITY (macro defined), or drive `tx`=1 and go to STOP.
- **PARITY:** on `TX_tick`, drive `tx`=1 and go to STOP.
- **STOP:** on `TX_tick`, pulse `frame_done`, clear `busy`, and go to IDLE. `tx` stays 1.
- **Arbitration:**
  - No grant is issued while `busy` is high.
  - Deasserting `req_valid` before the grant is legal; that requester is simply skipped.
  - `req_data` is sampled only in the accept cycle.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0.

## Timing
- **Reset values:** `tx`=1, `req_ready`=0, `busy`=0, `frame_done`=0, `grant_id`=0, `last`=NUM_REQ-1 (requester 0 has first priority), state IDLE.
- **Reset mid-frame:** `tx` returns to 1 asynchronously, the byte is discarded, and there is no `frame_done`.
- **Accept:** `req_ready` is asserted in the same cycle the request is seen in IDLE (combinational from registered state and `req_valid`). `busy` rises the next cycle.
- **Frame length:** the line is low 1 tick period after the first tick following accept. The frame lasts 2+DATA_WIDTH ticks (+1 with parity).
- **Back-to-back:** the earliest next accept is the cycle after `frame_done`.
- **`tx`:** registered, changes only on cycles where `TX_tick`=1.

## Configuration
- **`UART_ARB_PARITY_EN` defined:** the PARITY state is compiled in. The parity bit is even parity (XOR of the data bits) and follows the last data bit. Frame = 11 ticks for DATA_WIDTH=8.
- **Undefined:** no PARITY state. STOP follows the last data bit directly. Frame = 10 ticks.

## Test plan
- **Single request, parity off:** reset; req_valid=4'b0001, data0=8'hA5 → `req_ready`=0001 for 1 cycle. `tx` sequence per tick: 0,1,0,1,0,0,1,0,1,1. One `frame_done`, `grant_id`=0.
- **Round-robin:** all four requesters valid, data 8'h11/22/33/44 → grants in order 0,1,2,3,0. Each frame is intact; no accept while `busy`=1.
- **Simultaneous tick and accept in IDLE:** the start bit appears on the next tick, not the coincident one. Start-bit low width = exactly one tick period.
- **Mid-frame async reset:** assert `rst`=0 during DATA bit 3 → `tx`=1 and `busy`=0 immediately. After release, requester 0 has priority and no `frame_done` is seen.
- **Withdrawn request:** req_valid[2] pulses for 1 cycle while `busy`=1 and then drops → requester 2 is never granted, and `req_ready[2]` stays 0.
- **Parity (UART_ARB_PARITY_EN):** data=8'h07 → bit after MSB = 1. Data=8'h03 → 0. Frame = 11 ticks.
